// File: rtl/audio_adc_i2s_rx.sv
// WM8731 ADC I2S receiver: deserializes the codec's left/right words into the clk domain
// and publishes them as a held pair with a one-cycle sample_valid strobe.
module audio_adc_i2s_rx #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              KEY,
  input  logic              AUD_BCLK,
  input  logic              AUD_ADCLRCK,
  input  logic              AUD_ADCDAT,
  output logic [DATA_W-1:0] audio_inL,
  output logic [DATA_W-1:0] audio_inR,
  output logic              sample_valid,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_L,
    WAIT_L,
    SHIFT_R,
    WAIT_R
  } state_t;

  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lrck_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   bclk_prev;
  logic                   bclk_rise;
  logic                   lrck_q;
  logic                   dat_q;

  state_t                 state, state_n;
  logic                   lrck_prev, lrck_prev_n;
  logic [DATA_W-1:0]      shift_reg, shift_reg_n;
  logic [DATA_W-1:0]      hold_l, hold_l_n;
  logic [CNT_W-1:0]       bit_cnt, bit_cnt_n;
  logic                   l_ok, l_ok_n;
  logic [DATA_W-1:0]      audio_inL_n, audio_inR_n;
  logic                   sample_valid_n, frame_err_n;
  logic                   chan_start;
  logic [DATA_W-1:0]      shifted;

  // The edge pulse is registered together with LRCK/DAT so all three stay cycle-aligned.
  always_ff @(posedge clk) begin
    if (!KEY) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
      bclk_prev <= 1'b0;
      bclk_rise <= 1'b0;
      lrck_q    <= 1'b0;
      dat_q     <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], AUD_ADCLRCK};
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0], AUD_ADCDAT};
      bclk_prev <= bclk_sync[SYNC_STAGES-1];
      bclk_rise <= bclk_sync[SYNC_STAGES-1] & ~bclk_prev;
      lrck_q    <= lrck_sync[SYNC_STAGES-1];
      dat_q     <= dat_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!KEY) begin
      state        <= IDLE;
      lrck_prev    <= 1'b0;
      shift_reg    <= '0;
      hold_l       <= '0;
      bit_cnt      <= '0;
      l_ok         <= 1'b0;
      audio_inL    <= '0;
      audio_inR    <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_n;
      lrck_prev    <= lrck_prev_n;
      shift_reg    <= shift_reg_n;
      hold_l       <= hold_l_n;
      bit_cnt      <= bit_cnt_n;
      l_ok         <= l_ok_n;
      audio_inL    <= audio_inL_n;
      audio_inR    <= audio_inR_n;
      sample_valid <= sample_valid_n;
      frame_err    <= frame_err_n;
    end
  end

  always_comb begin
    state_n        = state;
    lrck_prev_n    = lrck_prev;
    shift_reg_n    = shift_reg;
    hold_l_n       = hold_l;
    bit_cnt_n      = bit_cnt;
    l_ok_n         = l_ok;
    audio_inL_n    = audio_inL;
    audio_inR_n    = audio_inR;
    sample_valid_n = 1'b0;
    frame_err_n    = frame_err;
    chan_start     = lrck_q != lrck_prev;
    shifted        = {shift_reg[DATA_W-2:0], dat_q};

    if (bclk_rise) begin
      lrck_prev_n = lrck_q;
      unique case (state)
        IDLE: begin
          if (chan_start && !lrck_q) begin
            state_n   = SHIFT_L;
            bit_cnt_n = '0;
          end
        end
        SHIFT_L, SHIFT_R: begin
          // A word-clock edge before the word is complete restarts on the new channel.
          if (chan_start) begin
            frame_err_n = 1'b1;
            l_ok_n      = 1'b0;
            bit_cnt_n   = '0;
            state_n     = lrck_q ? SHIFT_R : SHIFT_L;
          end else begin
            shift_reg_n = shifted;
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              bit_cnt_n = '0;
              if (state == SHIFT_L) begin
                hold_l_n = shifted;
                l_ok_n   = 1'b1;
                state_n  = WAIT_L;
              end else begin
                if (l_ok) begin
                  audio_inL_n    = hold_l;
                  audio_inR_n    = shifted;
                  sample_valid_n = 1'b1;
                end
                l_ok_n  = 1'b0;
                state_n = WAIT_R;
              end
            end else begin
              bit_cnt_n = bit_cnt + CNT_W'(1);
            end
          end
        end
        WAIT_L: begin
          if (chan_start && lrck_q) begin
            state_n   = SHIFT_R;
            bit_cnt_n = '0;
          end
        end
        WAIT_R: begin
          if (chan_start && !lrck_q) begin
            state_n   = SHIFT_L;
            bit_cnt_n = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_adc_i2s_rx.sv
// Self-checking bench for audio_adc_i2s_rx: drives I2S half-frames at clk/16 and compares
// every published pair, its latency, hold behaviour and frame_err against a frame-level model.
module tb_audio_adc_i2s_rx;

  localparam int DW     = 16;
  localparam int SYNC   = 2;
  localparam int PERIOD = 20;

  logic          clk;
  logic          KEY;
  logic          AUD_BCLK;
  logic          AUD_ADCLRCK;
  logic          AUD_ADCDAT;
  logic [DW-1:0] audio_inL;
  logic [DW-1:0] audio_inR;
  logic          sample_valid;
  logic          frame_err;

  audio_adc_i2s_rx #(.DATA_W(DW), .SYNC_STAGES(SYNC)) dut (
    .clk          (clk),
    .KEY          (KEY),
    .AUD_BCLK     (AUD_BCLK),
    .AUD_ADCLRCK  (AUD_ADCLRCK),
    .AUD_ADCDAT   (AUD_ADCDAT),
    .audio_inL    (audio_inL),
    .audio_inR    (audio_inR),
    .sample_valid (sample_valid),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] expQ[$];
  logic [DW-1:0] pubL = '0;
  logic [DW-1:0] pubR = '0;
  bit          checking  = 0;
  bit          prevValid = 0;
  time         riseTime  = 0;
  time         lastStrobe = 0;
  time         prevStrobe = 0;

  // Frame-level model state: which word-clock level was last seen, whether a left start has
  // been seen since reset, whether the current half is being captured, and the pending left word.
  bit          mPrevLr = 0;
  bit          mSynced = 0;
  bit          mActive = 0;
  bit          mPrevComplete = 1;
  bit          mLeftOk = 0;
  bit          errExp  = 0;
  logic [DW-1:0] mLeftWord = '0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // One half-frame of nBclk bit clocks: delay slot, DW data bits MSB first, random filler.
  // rstAt >= 0 pulses KEY low for rstLen clk cycles during the low phase of that bit.
  task automatic applyStimulus(input bit lr, input logic [DW-1:0] word, input int nBclk,
                               input int rstAt, input int rstLen);
    bit start;
    start   = (lr != mPrevLr);
    mPrevLr = lr;
    if (start) begin
      if (mActive && !mPrevComplete) begin
        errExp  = 1;
        mLeftOk = 0;
      end
      if (!lr) begin
        mSynced = 1;
        mActive = 1;
      end else begin
        mActive = mSynced;
      end
    end else begin
      mActive = 0;
    end
    mPrevComplete = (nBclk - 1 >= DW);
    for (int i = 0; i < nBclk; i++) begin
      AUD_BCLK    = 1'b0;
      AUD_ADCLRCK = lr;
      AUD_ADCDAT  = (i >= 1 && i <= DW) ? word[DW-i] : 1'($urandom);
      if (i == rstAt) begin
        KEY = 1'b0;
        waitClk(rstLen);
        KEY = 1'b1;
        waitClk(8 - rstLen);
        mSynced = 0;
        mActive = 0;
        mLeftOk = 0;
        errExp  = 0;
        mPrevComplete = 1;
      end else begin
        waitClk(8);
      end
      AUD_BCLK = 1'b1;
      if (i == DW) begin
        if (lr) riseTime = $time;
        if (mActive && !lr) begin
          mLeftOk   = 1;
          mLeftWord = word;
        end else if (mActive && lr && mLeftOk) begin
          expQ.push_back({mLeftWord, word});
          mLeftOk = 0;
        end
      end
      waitClk(8);
    end
    checkOutput("frame_err", 32'(frame_err), 32'(errExp));
  endtask

  // Output monitor: every strobe must match the next expected pair; between strobes the
  // outputs must hold the last published pair (zero after reset).
  always @(negedge clk) begin
    if (checking) begin
      if (!KEY) begin
        pubL = '0;
        pubR = '0;
        checkOutput("valid_in_reset", 32'(sample_valid), 32'd0);
      end
      if (sample_valid) begin
        checkOutput("back_to_back_strobe", 32'(prevValid), 32'd0);
        if (expQ.size() == 0) begin
          checkOutput("unexpected_strobe", 32'(sample_valid), 32'd0);
        end else begin
          logic [31:0] e;
          e = expQ.pop_front();
          pubL = e[31:16];
          pubR = e[15:0];
          checkOutput("latency", 32'(($time - riseTime + 1) / PERIOD), 32'(SYNC + 2));
        end
        prevStrobe = lastStrobe;
        lastStrobe = $time;
      end
      checkOutput("audio_inL", 32'(audio_inL), 32'(pubL));
      checkOutput("audio_inR", 32'(audio_inR), 32'(pubR));
      prevValid = sample_valid;
    end
  end

  initial begin
    KEY         = 1'b0;
    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = 1'b0;
    AUD_ADCDAT  = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      AUD_BCLK = ~AUD_BCLK;
    end
    @(negedge clk);
    checkOutput("reset_L", 32'(audio_inL), 32'd0);
    checkOutput("reset_R", 32'(audio_inR), 32'd0);
    checkOutput("reset_valid", 32'(sample_valid), 32'd0);
    checkOutput("reset_err", 32'(frame_err), 32'd0);
    #1;
    KEY      = 1'b1;
    AUD_BCLK = 1'b0;
    checking = 1;

    // Single frame, preceded by a right half that must be ignored while idle
    applyStimulus(1'b1, 16'($urandom), 32, -1, 0);
    applyStimulus(1'b0, 16'h1234, 32, -1, 0);
    applyStimulus(1'b1, 16'hABCD, 32, -1, 0);

    // Back-to-back frames, one LRCK period apart
    applyStimulus(1'b0, 16'h8000, 32, -1, 0);
    applyStimulus(1'b1, 16'h7FFF, 32, -1, 0);
    applyStimulus(1'b0, 16'hFFFF, 32, -1, 0);
    applyStimulus(1'b1, 16'h0001, 32, -1, 0);
    checkOutput("strobe_interval", 32'((lastStrobe - prevStrobe) / PERIOD), 32'd1024);

    // Random words and half-frame lengths at or above the minimum
    for (int f = 0; f < 6; f++) begin
      applyStimulus(1'b0, 16'($urandom), $urandom_range(17, 40), -1, 0);
      applyStimulus(1'b1, 16'($urandom), $urandom_range(17, 40), -1, 0);
    end

    // Short left half (10 data bits): no strobe, sticky error, next frame still captured
    applyStimulus(1'b0, 16'($urandom), 11, -1, 0);
    applyStimulus(1'b1, 16'($urandom), 32, -1, 0);
    applyStimulus(1'b0, 16'h5A5A, 32, -1, 0);
    applyStimulus(1'b1, 16'hC3C3, 32, -1, 0);

    // One-cycle reset during the right word, then a fresh frame
    applyStimulus(1'b0, 16'($urandom), 32, -1, 0);
    applyStimulus(1'b1, 16'($urandom), 32, 5, 1);
    applyStimulus(1'b0, 16'h1111, 32, -1, 0);
    applyStimulus(1'b1, 16'h2222, 32, -1, 0);

    // Longer reset released in the middle of a right half
    applyStimulus(1'b0, 16'($urandom), 32, -1, 0);
    applyStimulus(1'b1, 16'($urandom), 32, 8, 6);
    applyStimulus(1'b0, 16'h0F0F, 32, -1, 0);
    applyStimulus(1'b1, 16'hF0F0, 32, -1, 0);

    applyStimulus(1'b0, 16'($urandom), 32, -1, 0);
    waitClk(20);
    checkOutput("pending_strobes", 32'(expQ.size()), 32'd0);
    checking = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_adc_i2s_rx.md
# audio_adc_i2s_rx

Upstream capture stage for the adaptive noise canceller. The block deserializes the WM8731 ADC I2S stream (`AUD_BCLK`, `AUD_ADCLRCK`, `AUD_ADCDAT`) into 16-bit two's-complement left/right samples in the 50 MHz `clk` domain. It presents them as a held pair (`audio_inL`, `audio_inR`) with a one-cycle `sample_valid` strobe. The LMS stage consumes `audio_inL` directly as its primary input.

## Interface
Parameters:
- `DATA_W`, 16: captured bits per channel, MSB first; any further bits in a half-frame are ignored.
- `SYNC_STAGES`, 2: flip-flop stages on each codec input; minimum 2.

Ports:
- `clk`  in  1  50 MHz system clock; the only clock in the block.
- `KEY`  in  1  reset, synchronous, active-low (0 = reset), sampled on `clk` rising edge.
- `AUD_BCLK`  in  1  codec bit clock, asynchronous to `clk`, at most clk/8.
- `AUD_ADCLRCK`  in  1  codec word clock, asynchronous; 0 = left, 1 = right.
- `AUD_ADCDAT`  in  1  codec serial data, asynchronous; changes on `AUD_BCLK` falling edge.
- `audio_inL`  out  DATA_W  last complete left sample, held between strobes.
- `audio_inR`  out  DATA_W  last complete right sample, held between strobes.
- `sample_valid`  out  1  one-`clk` pulse when a new L/R pair is published.
- `frame_err`  out  1  sticky flag for a short half-frame; cleared only by reset.

## Operation
- **Synchronisation.** All three codec inputs pass through `SYNC_STAGES` flops with identical depth, so data and clocks stay aligned.
  - `bclk_rise` is a one-cycle internal pulse: synchronized BCLK = 1 and its previous value = 0.
  - LRCK and DAT are sampled only in cycles where `bclk_rise` = 1.
- **Channel start.** At a `bclk_rise` where sampled LRCK differs from the LRCK value held at the previous `bclk_rise`, a channel start is declared. This is the I2S one-bit delay slot, so no data is captured on it.
- **State machine** (all transitions occur only on `bclk_rise`):
  - IDLE: wait for a left start (LRCK 1→0). Any right start is ignored. Go to SHIFT_L with bit count = 0.
  - SHIFT_L: shift DAT into the left shift register, MSB first, one bit per `bclk_rise`.
    - After the DATA_W-th bit: latch it into the left hold register, set `l_ok`, go to WAIT_L.
  - WAIT_L: ignore bits until a right start (LRCK 0→1), then go to SHIFT_R.
  - SHIFT_R: same as SHIFT_L for the right channel.
    - After the DATA_W-th bit: if `l_ok`, copy both hold registers to `audio_inL`/`audio_inR`, pulse `sample_valid`, and clear `l_ok`. Go to WAIT_R.
  - WAIT_R: on a left start, go to SHIFT_L.
- **Short half-frame.** An LRCK transition while in SHIFT_L or SHIFT_R before DATA_W bits have been shifted:
  - set `frame_err`, discard the partial word, clear `l_ok`;
  - treat the transition as a normal channel start of the new channel (→ SHIFT_L or SHIFT_R);
  - no strobe for that frame.
- **Data transfer.** Outputs are raw two's-complement bit copies, with no sign extension or scaling. 0x8000 passes through as −32768.
- **Reset.** While `KEY` = 0:
  - `audio_inL` = 0, `audio_inR` = 0, `sample_valid` = 0, `frame_err` = 0;
  - shift registers, hold registers, bit count and `l_ok` are cleared; state = IDLE;
  - synchronizer flops are cleared to 0.
- **Reset mid-frame.** Any in-progress word is dropped. The next strobe requires a complete left followed by a complete right after reset release.

## Timing
- **Latency.** Let D be the `clk` cycle in which `bclk_rise` = 1 for the DATA_W-th right bit. Registers update at the end of D; `audio_inL`/`audio_inR` change and `sample_valid` = 1 in cycle D+1 only.
- **Pin-to-output latency** = `SYNC_STAGES` + 2 `clk` edges after the BCLK rising edge at the pin.
- **Strobe width.** `sample_valid` is exactly one cycle wide and never asserted on two consecutive cycles.
- **Strobe rate.** Strobes occur once per LRCK period, e.g. every 1024 `clk` cycles at 48.828 kHz with 64 BCLK per frame.
- **Output hold.** Outputs are stable from one strobe to the next; a consumer may sample them at any time.
- **Simultaneous events.** `KEY` = 0 in the same cycle as a `bclk_rise`: reset wins and no shift occurs.
- **Minimum half-frame.** DATA_W + 1 BCLK periods. Longer half-frames are normal: extra bits are ignored and `frame_err` is not set.

## Test plan
- **Reset.** `KEY` = 0 for 4 cycles with BCLK toggling → all outputs 0, no strobe.
- **Single frame.** BCLK = clk/16, 32 BCLK per half-frame, L = 0x1234, R = 0xABCD:
  - exactly one `sample_valid` pulse, with `audio_inL` = 0x1234 and `audio_inR` = 0xABCD;
  - the pulse lands `SYNC_STAGES` + 2 cycles after the pin BCLK edge of the 16th right bit.
- **Back-to-back frames.** (0x8000, 0x7FFF) then (0xFFFF, 0x0001) → two pulses 1024 cycles apart carrying those exact values, held constant between pulses.
- **Release mid-right-channel.** Release reset during a right half-frame → no strobe for that partial frame; the first strobe follows the next full L/R pair.
- **Short half-frame.** LRCK toggles after 10 left bits:
  - `frame_err` = 1 and no strobe for that frame;
  - the next good frame strobes correctly and `frame_err` remains 1.
- **Reset mid-SHIFT_R.** `KEY` = 0 for 1 cycle during SHIFT_R:
  - outputs are 0 on the next cycle;
  - no strobe until a fresh complete frame, which is then captured correctly.
